// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with frame-synchronous updates,
// leading-zero blanking, optional hex glyphs and selectable pin polarity.
module seg7_scan_driver #(
   parameter int NUM_DIGITS     = 4,
   parameter int CLK_DIV        = 50000,
   parameter int HEX_MODE       = 0,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int AN_ACTIVE_LOW  = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
   localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   logic [PW-1:0]             prescaler;
   logic [IW-1:0]             index;
   logic                      tick;
   logic                      wrap;
   logic [4*NUM_DIGITS-1:0]   shadow_digits;
   logic [4*NUM_DIGITS-1:0]   active_digits;
   logic [NUM_DIGITS-1:0]     shadow_dp;
   logic [NUM_DIGITS-1:0]     active_dp;
   logic                      shadow_blz;
   logic                      active_blz;
   logic [3:0]                cur_digit;
   logic                      cur_dp;
   logic                      cur_blank;
   logic [NUM_DIGITS-1:0]     an_raw;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1111110;
         4'h1:    s = 7'b0110000;
         4'h2:    s = 7'b1101101;
         4'h3:    s = 7'b1111001;
         4'h4:    s = 7'b0110011;
         4'h5:    s = 7'b1011011;
         4'h6:    s = 7'b1011111;
         4'h7:    s = 7'b1110000;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1111011;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b0011111;
         4'hC:    s = 7'b1001110;
         4'hD:    s = 7'b0111101;
         4'hE:    s = 7'b1001111;
         default: s = 7'b1000111;
      endcase
      if (HEX_MODE == 0 && v > 4'd9) s = 7'b0000001;
      return s;
   endfunction

   assign tick = (prescaler == PRE_LAST);
   assign wrap = tick && (index == IDX_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         index     <= '0;
      end else if (tick) begin
         prescaler <= '0;
         index     <= (index == IDX_LAST) ? '0 : index + 1'b1;
      end else begin
         prescaler <= prescaler + 1'b1;
      end
   end

   // Active set only changes at a frame wrap so a frame never mixes old and new data;
   // a load coinciding with the wrap stays in the shadow for the following frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_digits <= '0;
         shadow_dp     <= '0;
         shadow_blz    <= 1'b0;
         active_digits <= '0;
         active_dp     <= '0;
         active_blz    <= 1'b0;
         pending       <= 1'b0;
         frame_done    <= 1'b0;
      end else begin
         if (load) begin
            shadow_digits <= digits_in;
            shadow_dp     <= dp_in;
            shadow_blz    <= blank_lz;
         end
         if (wrap && pending) begin
            active_digits <= shadow_digits;
            active_dp     <= shadow_dp;
            active_blz    <= shadow_blz;
         end
         pending    <= load | (pending & ~wrap);
         frame_done <= wrap;
      end
   end

   always_comb begin
      logic zero_run;
      zero_run  = 1'b1;
      cur_digit = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      an_raw    = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run & (active_digits[4*k +: 4] == 4'd0);
         if (index == IW'(k)) begin
            cur_digit = active_digits[4*k +: 4];
            cur_dp    = active_dp[k];
            cur_blank = active_blz && (k != 0) && zero_run;
            an_raw[k] = 1'b1;
         end
      end
   end

   // XOR with the "off" level applies the pin polarity inside the output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         dp  <= DP_OFF;
         an  <= AN_OFF;
      end else begin
         seg <= (cur_blank ? 7'd0 : decode(cur_digit)) ^ SEG_OFF;
         dp  <= cur_dp ^ DP_OFF;
         an  <= an_raw ^ AN_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Checks three parameterisations of seg7_scan_driver against a frame-arithmetic
// model: display content is derived from edge counts, frame length and load history.
module tb_seg7_scan_driver;

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [7:0] an;
      logic       pending;
      logic       frame_done;
   } obs_t;

   typedef struct {
      int          e;
      logic [15:0] dig;
      logic [3:0]  dpv;
      logic        blz;
   } load_t;

   localparam int N_TAB  [3] = '{4, 4, 1};
   localparam int D_TAB  [3] = '{4, 3, 1};
   localparam int HEX_TAB[3] = '{0, 1, 1};
   localparam int SL_TAB [3] = '{0, 1, 0};
   localparam int AL_TAB [3] = '{0, 1, 0};
   localparam logic [6:0] GLYPH [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
      7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        blank_lz;

   logic [6:0] seg_a, seg_b, seg_c;
   logic       dp_a, dp_b, dp_c;
   logic [3:0] an_a, an_b;
   logic [0:0] an_c;
   logic       pend_a, pend_b, pend_c;
   logic       fd_a, fd_b, fd_c;

   obs_t  obs [3];
   obs_t  exp_v;
   int    edge_cnt = -1;
   load_t loads[$];
   int    n_checks = 0;
   int    n_fail = 0;

   seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(0),
                      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .an(an_a), .pending(pend_a),
      .frame_done(fd_a));

   seg7_scan_driver #(.NUM_DIGITS(4), .CLK_DIV(3), .HEX_MODE(1),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .dp_in(dp_in),
      .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .an(an_b), .pending(pend_b),
      .frame_done(fd_b));

   seg7_scan_driver #(.NUM_DIGITS(1), .CLK_DIV(1), .HEX_MODE(1),
                      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in[3:0]), .dp_in(dp_in[0]),
      .blank_lz(blank_lz), .seg(seg_c), .dp(dp_c), .an(an_c), .pending(pend_c),
      .frame_done(fd_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      obs[0] = '{seg_a, dp_a, {4'b0, an_a}, pend_a, fd_a};
      obs[1] = '{seg_b, dp_b, {4'b0, an_b}, pend_b, fd_b};
      obs[2] = '{seg_c, dp_c, {7'b0, an_c}, pend_c, fd_c};
   end

   // Edge counter since reset release plus a log of every load and the edge that took it.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= -1;
         loads.delete();
      end else begin
         edge_cnt <= edge_cnt + 1;
         if (load) loads.push_back('{edge_cnt + 1, digits_in, dp_in, blank_lz});
      end
   end

   // Expected outputs after edge edge_cnt: shown digit is (e / CLK_DIV) % N, and the
   // shown data is the newest load taken strictly before the latest completed frame wrap.
   function automatic obs_t model(input int d);
      obs_t        r;
      int          n, cd, f, wl, idx, l, wnext;
      logic [31:0] act_dig;
      logic [7:0]  act_dp;
      logic        act_blz;
      logic [6:0]  raw;
      logic [3:0]  val;
      logic [7:0]  mask;
      logic [7:0]  an_raw;
      n       = N_TAB[d];
      cd      = D_TAB[d];
      f       = n * cd;
      mask    = 8'((1 << n) - 1);
      act_dig = '0;
      act_dp  = '0;
      act_blz = 1'b0;
      r       = '0;
      if (edge_cnt < 0) begin
         r.seg = (SL_TAB[d] != 0) ? 7'h7f : 7'h00;
         r.dp  = (SL_TAB[d] != 0);
         r.an  = (AL_TAB[d] != 0) ? mask : 8'h00;
         return r;
      end
      if (edge_cnt / f > 0) begin
         wl = (edge_cnt / f) * f - 1;
         foreach (loads[i]) begin
            if (loads[i].e < wl) begin
               act_dig = {16'h0, loads[i].dig};
               act_dp  = {4'h0, loads[i].dpv};
               act_blz = loads[i].blz;
            end
         end
      end
      act_dig = act_dig & ((32'h1 << (4 * n)) - 1);
      if (loads.size() > 0) begin
         l     = loads[loads.size() - 1].e;
         wnext = (((l + 1) / f) + 1) * f - 1;
         r.pending = (wnext > edge_cnt);
      end
      r.frame_done = ((edge_cnt + 1) % f == 0);
      idx = (edge_cnt / cd) % n;
      val = act_dig[4*idx +: 4];
      if (act_blz && idx > 0 && ((act_dig >> (4 * idx)) == 0)) raw = 7'd0;
      else if (HEX_TAB[d] == 0 && val > 4'd9) raw = 7'b0000001;
      else raw = GLYPH[val];
      r.seg  = (SL_TAB[d] != 0) ? ~raw : raw;
      r.dp   = act_dp[idx] ^ (SL_TAB[d] != 0);
      an_raw = 8'(1 << idx);
      r.an   = (AL_TAB[d] != 0) ? (~an_raw & mask) : an_raw;
      return r;
   endfunction

   task automatic start_load(input logic [15:0] dg, input logic [3:0] p, input logic b);
      digits_in = dg;
      dp_in     = p;
      blank_lz  = b;
      load      = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         exp_v = model(d);
         n_checks++;
         if (obs[d] !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reset_hold dut%0d: got %h required %h", d, obs[d], exp_v);
         end
      end
      rst_n = 1'b1;
      start_load(16'h0789, 4'b0010, 1'b0);
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int d = 0; d < 3; d++) begin
            exp_v = model(d);
            n_checks++;
            if (obs[d] !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL reset_release dut%0d edge %0d: got %h required %h",
                        d, edge_cnt, obs[d], exp_v);
            end
         end
      end
      start_load(16'h4321, 4'b1111, 1'b0);
      @(negedge clk);
      load = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         exp_v = model(d);
         n_checks++;
         if (obs[d] !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reset_midframe dut%0d: got %h required %h", d, obs[d], exp_v);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_scan_order();
      start_load(16'h1234, 4'b0000, 1'b0);
      for (int c = 0; c < 56; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int d = 0; d < 3; d++) begin
            exp_v = model(d);
            n_checks++;
            if (obs[d] !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL scan_order dut%0d edge %0d: got %h required %h",
                        d, edge_cnt, obs[d], exp_v);
            end
         end
      end
   endtask

   task automatic test_update();
      bit did1 = 0;
      bit did2 = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int d = 0; d < 3; d++) begin
            exp_v = model(d);
            n_checks++;
            if (obs[d] !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL frame_update dut%0d edge %0d: got %h required %h",
                        d, edge_cnt, obs[d], exp_v);
            end
         end
         if (!did1 && ((edge_cnt + 1) / 4) % 4 == 1) begin
            start_load(16'h5678, 4'b0001, 1'b0);
            did1 = 1;
         end else if (did1 && !did2 && c > 20 && (edge_cnt + 1) % 16 == 15) begin
            start_load(16'h9ABC, 4'b1000, 1'b0);
            did2 = 1;
         end
      end
   endtask

   task automatic test_blanking();
      start_load(16'h0050, 4'b0100, 1'b1);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int d = 0; d < 3; d++) begin
            exp_v = model(d);
            n_checks++;
            if (obs[d] !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL blank_0050 dut%0d edge %0d: got %h required %h",
                        d, edge_cnt, obs[d], exp_v);
            end
         end
         if (c == 25) start_load(16'h0000, 4'(($urandom)), 1'b1);
      end
   endtask

   task automatic test_hex();
      start_load(16'hFA0C, 4'b0000, 1'b0);
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int d = 0; d < 3; d++) begin
            exp_v = model(d);
            n_checks++;
            if (obs[d] !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL hex_codes dut%0d edge %0d: got %h required %h",
                        d, edge_cnt, obs[d], exp_v);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int d = 0; d < 3; d++) begin
            exp_v = model(d);
            n_checks++;
            if (obs[d] !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL random dut%0d edge %0d: got %h required %h",
                        d, edge_cnt, obs[d], exp_v);
            end
         end
         if ($urandom_range(0, 11) == 0)
            start_load(16'($urandom), 4'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         load = 1'b0;
         for (int d = 0; d < 3; d++) begin
            exp_v = model(d);
            n_checks++;
            if (obs[d] !== exp_v) begin
               n_fail++;
               $display("[TB] FAIL back_to_back dut%0d edge %0d: got %h required %h",
                        d, edge_cnt, obs[d], exp_v);
            end
         end
         if (c < 35)
            start_load(16'($urandom) & 16'h0F0F, 4'($urandom), 1'($urandom));
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      load      = 1'b0;
      digits_in = '0;
      dp_in     = '0;
      blank_lz  = 1'b0;
      test_reset();
      test_scan_order();
      test_update();
      test_blanking();
      test_hex();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-segment 7-segment display. It holds a BCD/hex value per digit and scans the digits one at a time at a programmable refresh rate. Per-digit decimal points, leading-zero blanking, polarity selection and tear-free frame-synchronous updates are supported. It sits between the counter/arithmetic datapath and the board's segment and anode pins, and supersedes single-digit combinational decoding.

## Interface
- NUM_DIGITS, 4: number of digits scanned, legal range 1..8.
- CLK_DIV, 50000: clock cycles each digit is held; legal value ≥1.
- HEX_MODE, 0: 0 shows codes 10..15 as a dash; 1 shows them as A b C d E F.
- SEG_ACTIVE_LOW, 0: 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 0: 1 inverts an at the pins.

Ports:
- clk, input, 1: single system clock; all logic is on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- load, input, 1: one-cycle strobe that captures digits_in, dp_in and blank_lz into the shadow register.
- digits_in, input, 4*NUM_DIGITS: digit k occupies [4k+3:4k]; digit 0 is least significant and rightmost.
- dp_in, input, NUM_DIGITS: per-digit decimal point request.
- blank_lz, input, 1: enables leading-zero blanking.
- seg, output, 7: segments {a,b,c,d,e,f,g}, registered.
- dp, output, 1: decimal point for the current digit, registered.
- an, output, NUM_DIGITS: one-hot digit enable, registered.
- pending, output, 1: shadow holds data not yet shown.
- frame_done, output, 1: one-cycle pulse at each frame wrap.

## Operation
Registers:
- Prescaler: width clog2(CLK_DIV), minimum 1.
- Digit index: width clog2(NUM_DIGITS), minimum 1.
- Shadow set and active set, each containing digits, dp and blank_lz.
- pending flag.

Scanning:
- tick is asserted when prescaler == CLK_DIV-1. On tick the prescaler returns to 0; otherwise it increments.
- On tick the index advances by one. At NUM_DIGITS-1 it wraps to 0. With NUM_DIGITS=1 the index stays at 0 and every tick is a wrap.
- Scan order is digit 0, 1, …, NUM_DIGITS-1, then repeat.

Update path:
- wrap = tick AND index == NUM_DIGITS-1.
- On wrap, if pending is set, the shadow is copied into the active set and frame_done pulses. frame_done pulses on every wrap, whether or not a copy happens.
- pending_next = load | (pending & ~wrap).
- If load and wrap occur in the same cycle, the copy uses the pre-load shadow. The newly loaded value stays pending until the next wrap.
- Multiple loads within one frame: the last one wins.

Decode (abcdefg, active-high before polarity):
- Digits 0–9: 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011.
- Codes 10–15, HEX_MODE=0: 0000001 (dash).
- Codes 10–15, HEX_MODE=1: A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.

Blanking:
- With active blank_lz=1, digit k>0 is blanked when it and all digits above it are 0.
- Digit 0 is never blanked.
- A blanked digit drives seg=0000000 before polarity, but dp is still driven from dp_in.

Outputs:
- an has exactly the bit at the current index active and all other bits inactive.
- Polarity inversion is applied last, inside the output registers.

## Timing
Reset (rst_n low, asynchronous):
- Prescaler, index, shadow, active set and pending are all cleared to 0.
- seg = all segments off, dp = off, an = all digits off, with the parameter-selected polarity applied.
- frame_done = 0.

After reset release:
- The first rising edge loads the outputs with digit 0 of the active set, i.e. '0' with an[0] active.
- Output registers reflect the current index with 1-cycle latency. seg, dp and an change together, on the clock after the index changes, so there is no cross-digit ghosting between them.

Frame and update timing:
- Digit dwell is CLK_DIV cycles; frame length is NUM_DIGITS*CLK_DIV cycles.
- Load-to-visible latency: at most one frame plus 1 cycle, and at least 1 cycle after the next wrap.
- frame_done is asserted in the cycle after the wrap edge and lasts 1 cycle. pending falls in the same cycle.

Reset mid-frame: all state returns to the reset values immediately and scanning restarts from digit 0. Any pending data is lost.

## Test plan
1. Reset values: NUM_DIGITS=4, both polarities. Hold rst_n=0 mid-scan → seg, dp and an all off for the given polarity, pending=0, frame_done=0. Release → the next edge shows an=0001 and seg=1111110.
2. Scan order: CLK_DIV=4, load digits_in=16'h1234, then wait one wrap. an must step 0001→0010→0100→1000, 4 cycles each. seg must follow 0110011, 1111001, 1101101, 0110000. frame_done pulses every 16 cycles.
3. Frame-synchronous update: load 16'h5678 at index 1. The display stays 1234 until the wrap, with pending=1. After the wrap it shows 5678 and pending=0. A second load in the wrap cycle gives pending=1 after the wrap, and that value appears one frame later.
4. Leading-zero blanking: blank_lz=1.
   - 16'h0050, dp_in=4'b0100 → digits 3 and 2 seg=0000000, with dp=1 on digit 2; digit 1 =1011011; digit 0 =1111110.
   - 16'h0000 → only digit 0 lit.
5. Codes 10–15: load 16'hFA0C. HEX_MODE=0 → 0000001 on digits 3, 2 and 0. HEX_MODE=1 → 1000111, 1110111, 1111110, 1001110. With SEG_ACTIVE_LOW=1 and AN_ACTIVE_LOW=1 every seg, dp and an bit is inverted.
6. Edge parameters: NUM_DIGITS=1 with CLK_DIV=1 → an stays at 1, a wrap happens every cycle, and a load is visible 2 cycles later.
